// File: rtl/rename_stage.sv
// rename_stage: register rename with RAT, circular free list and one output register stage
//
// Optional feature: define RENAME_FREE_BYPASS_EN so that PRNs freed in a cycle
// can be allocated in that same cycle (after entries already in the free list).
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   dec_valid/dec_ready           decoder handshake
//   dec_pc                        instruction PC
//   dec_src_valid/dec_src_arn     source operands (architectural)
//   dec_dst_valid/dec_dst_arn     destination operands (architectural)
//   inst_valid/inst_ready         dispatch handshake toward ROB
//   pc                            registered dec_pc
//   src_prn_valid/src_prn         renamed sources
//   dst_prn_valid/dst_prn         newly allocated destinations
//   mapping_inputs_valid/prn/arn  previous mapping overwritten by each destination
//   freed_prns_valid/freed_prns   PRNs returned at commit
module rename_stage #(
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3,
    parameter int ARCH_REGS    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    dec_valid,
    output logic                    dec_ready,
    input  logic [63:0]             dec_pc,
    input  logic [MAX_OPERANDS-1:0] dec_src_valid,
    input  logic [4:0]              dec_src_arn [MAX_OPERANDS],
    input  logic [MAX_OPERANDS-1:0] dec_dst_valid,
    input  logic [4:0]              dec_dst_arn [MAX_OPERANDS],
    output logic                    inst_valid,
    input  logic                    inst_ready,
    output logic [63:0]             pc,
    output logic [MAX_OPERANDS-1:0] src_prn_valid,
    output logic [PRN_BITS-1:0]     src_prn [MAX_OPERANDS],
    output logic [MAX_OPERANDS-1:0] dst_prn_valid,
    output logic [PRN_BITS-1:0]     dst_prn [MAX_OPERANDS],
    output logic [MAX_OPERANDS-1:0] mapping_inputs_valid,
    output logic [PRN_BITS-1:0]     mapping_inputs_prn [MAX_OPERANDS],
    output logic [32:0]             mapping_inputs_arn [MAX_OPERANDS],
    input  logic [MAX_OPERANDS-1:0] freed_prns_valid,
    input  logic [PRN_BITS-1:0]     freed_prns [MAX_OPERANDS]
);
    localparam int DEPTH = 1 << PRN_BITS;
    localparam logic [PRN_BITS:0] FULL = {1'b1, {PRN_BITS{1'b0}}};

    logic [PRN_BITS-1:0] rat_q [ARCH_REGS];
    logic [PRN_BITS-1:0] rat_d [ARCH_REGS];
    logic [PRN_BITS-1:0] fl_q [DEPTH];
    logic [PRN_BITS-1:0] fl_d [DEPTH];
    logic [PRN_BITS-1:0] head_q, head_d, tail_q, tail_d, npush, npop;
    logic [PRN_BITS:0]   cnt_q, cnt_d, need, avail;
    logic                accept, keep, val_q, val_d;
    logic [63:0]         pc_q, pc_d;
    logic [MAX_OPERANDS-1:0] sv_q, sv_d, dv_q, dv_d, mv_q, mv_d;
    logic [PRN_BITS-1:0] src_q [MAX_OPERANDS];
    logic [PRN_BITS-1:0] src_d [MAX_OPERANDS];
    logic [PRN_BITS-1:0] dst_q [MAX_OPERANDS];
    logic [PRN_BITS-1:0] dst_d [MAX_OPERANDS];
    logic [PRN_BITS-1:0] map_q [MAX_OPERANDS];
    logic [PRN_BITS-1:0] map_d [MAX_OPERANDS];
    logic [32:0]         marn_q [MAX_OPERANDS];
    logic [32:0]         marn_d [MAX_OPERANDS];

    // Freed PRNs are written at the tail in slot order; once the list is full
    // the remaining pushes of the cycle are dropped.
    always_comb begin
        fl_d  = fl_q;
        npush = '0;
        for (int i = 0; i < MAX_OPERANDS; i++) begin
            if (freed_prns_valid[i] && (cnt_q + {1'b0, npush}) < FULL) begin
                fl_d[tail_q + npush] = freed_prns[i];
                npush = npush + PRN_BITS'(1);
            end
        end
    end

    always_comb begin
        need = '0;
        for (int i = 0; i < MAX_OPERANDS; i++)
            need = need + (PRN_BITS+1)'(dec_dst_valid[i]);
    end

`ifdef RENAME_FREE_BYPASS_EN
    assign avail = cnt_q + {1'b0, npush};
`else
    assign avail = cnt_q;
`endif

    assign dec_ready = rst && (!val_q || inst_ready) && avail >= need;
    assign accept    = dec_valid && dec_ready;

    // Pops read the post-push view of the list so bypassed PRNs come out
    // behind existing entries. rat_d is updated destination by destination,
    // so a repeated ARN sees the PRN just given to its lower-index twin.
    always_comb begin
        keep  = val_q && !inst_ready;
        rat_d = rat_q;
        npop  = '0;
        val_d = accept || keep;
        pc_d  = accept ? dec_pc : (keep ? pc_q : '0);
        sv_d  = accept ? dec_src_valid : (keep ? sv_q : '0);
        dv_d  = accept ? dec_dst_valid : (keep ? dv_q : '0);
        mv_d  = accept ? dec_dst_valid : (keep ? mv_q : '0);
        for (int i = 0; i < MAX_OPERANDS; i++) begin
            src_d[i]  = keep ? src_q[i] : '0;
            dst_d[i]  = keep ? dst_q[i] : '0;
            map_d[i]  = keep ? map_q[i] : '0;
            marn_d[i] = keep ? marn_q[i] : '0;
            if (accept) begin
                src_d[i]  = dec_src_valid[i] ? rat_q[dec_src_arn[i]] : '0;
                dst_d[i]  = '0;
                map_d[i]  = '0;
                marn_d[i] = '0;
            end
        end
        for (int i = 0; i < MAX_OPERANDS; i++) begin
            if (accept && dec_dst_valid[i]) begin
                dst_d[i]  = fl_d[head_q + npop];
                map_d[i]  = rat_d[dec_dst_arn[i]];
                marn_d[i] = {28'b0, dec_dst_arn[i]};
                rat_d[dec_dst_arn[i]] = fl_d[head_q + npop];
                npop = npop + PRN_BITS'(1);
            end
        end
        head_d = head_q + npop;
        tail_d = tail_q + npush;
        cnt_d  = cnt_q + {1'b0, npush} - {1'b0, npop};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ARCH_REGS; i++) rat_q[i] <= PRN_BITS'(i);
            for (int i = 0; i < DEPTH; i++) fl_q[i] <= PRN_BITS'(i + ARCH_REGS);
            head_q <= '0;
            tail_q <= PRN_BITS'(DEPTH - ARCH_REGS);
            cnt_q  <= (PRN_BITS+1)'(DEPTH - ARCH_REGS);
            val_q  <= 1'b0;
            pc_q   <= '0;
            sv_q   <= '0;
            dv_q   <= '0;
            mv_q   <= '0;
            for (int i = 0; i < MAX_OPERANDS; i++) begin
                src_q[i]  <= '0;
                dst_q[i]  <= '0;
                map_q[i]  <= '0;
                marn_q[i] <= '0;
            end
        end else begin
            rat_q  <= rat_d;
            fl_q   <= fl_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            val_q  <= val_d;
            pc_q   <= pc_d;
            sv_q   <= sv_d;
            dv_q   <= dv_d;
            mv_q   <= mv_d;
            src_q  <= src_d;
            dst_q  <= dst_d;
            map_q  <= map_d;
            marn_q <= marn_d;
        end
    end

    assign inst_valid           = val_q;
    assign pc                   = pc_q;
    assign src_prn_valid        = sv_q;
    assign src_prn              = src_q;
    assign dst_prn_valid        = dv_q;
    assign dst_prn              = dst_q;
    assign mapping_inputs_valid = mv_q;
    assign mapping_inputs_prn   = map_q;
    assign mapping_inputs_arn   = marn_q;
endmodule

// File: tb/tb_rename_stage.sv
// tb_rename_stage: self-checking bench for rename_stage against a queue-based reference model
module tb_rename_stage;
    localparam int N = 3;

    logic        clk, rst, dec_valid, dec_ready, inst_valid, inst_ready;
    logic [63:0] dec_pc, pc;
    logic [2:0]  dec_src_valid, dec_dst_valid, src_prn_valid, dst_prn_valid;
    logic [2:0]  mapping_inputs_valid, freed_prns_valid;
    logic [4:0]  dec_src_arn [N];
    logic [4:0]  dec_dst_arn [N];
    logic [5:0]  src_prn [N];
    logic [5:0]  dst_prn [N];
    logic [5:0]  mapping_inputs_prn [N];
    logic [5:0]  freed_prns [N];
    logic [32:0] mapping_inputs_arn [N];

    rename_stage dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_pc(dec_pc), .dec_src_valid(dec_src_valid), .dec_src_arn(dec_src_arn),
        .dec_dst_valid(dec_dst_valid), .dec_dst_arn(dec_dst_arn),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .pc(pc),
        .src_prn_valid(src_prn_valid), .src_prn(src_prn),
        .dst_prn_valid(dst_prn_valid), .dst_prn(dst_prn),
        .mapping_inputs_valid(mapping_inputs_valid), .mapping_inputs_prn(mapping_inputs_prn),
        .mapping_inputs_arn(mapping_inputs_arn),
        .freed_prns_valid(freed_prns_valid), .freed_prns(freed_prns)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // reference model state
    int          rat [32];
    int          fl [$];
    bit          e_valid;
    logic [63:0] e_pc;
    logic [2:0]  e_sv, e_dv, e_mv;
    logic [5:0]  e_src [N];
    logic [5:0]  e_dst [N];
    logic [5:0]  e_map [N];
    logic [32:0] e_marn [N];
    bit          exp_rdy, rdy_seen;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) rat[i] = i;
        fl.delete();
        for (int p = 32; p < 64; p++) fl.push_back(p);
        e_valid = 0; e_pc = '0; e_sv = '0; e_dv = '0; e_mv = '0;
        for (int i = 0; i < N; i++) begin
            e_src[i] = '0; e_dst[i] = '0; e_map[i] = '0; e_marn[i] = '0;
        end
    endtask

    task automatic set_idle();
        dec_valid = 0; dec_pc = '0; dec_src_valid = '0; dec_dst_valid = '0;
        freed_prns_valid = '0;
        for (int i = 0; i < N; i++) begin
            dec_src_arn[i] = '0; dec_dst_arn[i] = '0; freed_prns[i] = '0;
        end
    endtask

    // Samples dec_ready, advances the model by one cycle using the current
    // inputs, then lets the DUT take the same clock edge.
    task automatic step();
        int  pq [$];
        int  need, avail;
        bit  acc;
        #1;
        rdy_seen = dec_ready;
        for (int i = 0; i < N; i++)
            if (freed_prns_valid[i] && fl.size() + pq.size() < 64) pq.push_back(int'(freed_prns[i]));
        need  = $countones(dec_dst_valid);
        avail = fl.size();
`ifdef RENAME_FREE_BYPASS_EN
        avail += pq.size();
`endif
        exp_rdy = (!e_valid || inst_ready) && avail >= need;
        acc = dec_valid && exp_rdy;
        foreach (pq[k]) fl.push_back(pq[k]);
        if (acc) begin
            e_valid = 1; e_pc = dec_pc; e_sv = dec_src_valid; e_dv = dec_dst_valid; e_mv = dec_dst_valid;
            for (int i = 0; i < N; i++) begin
                e_src[i]  = dec_src_valid[i] ? 6'(rat[dec_src_arn[i]]) : 6'd0;
                e_dst[i]  = '0;
                e_map[i]  = '0;
                e_marn[i] = '0;
                if (dec_dst_valid[i]) begin
                    e_dst[i]  = 6'(fl.pop_front());
                    e_marn[i] = {28'b0, dec_dst_arn[i]};
                end
            end
            for (int i = 0; i < N; i++) begin
                if (dec_dst_valid[i]) begin
                    e_map[i] = 6'(rat[dec_dst_arn[i]]);
                    for (int j = 0; j < i; j++)
                        if (dec_dst_valid[j] && dec_dst_arn[j] == dec_dst_arn[i]) e_map[i] = e_dst[j];
                end
            end
            for (int i = 0; i < N; i++)
                if (dec_dst_valid[i]) rat[dec_dst_arn[i]] = int'(e_dst[i]);
        end else if (inst_ready) begin
            e_valid = 0; e_pc = '0; e_sv = '0; e_dv = '0; e_mv = '0;
            for (int i = 0; i < N; i++) begin
                e_src[i] = '0; e_dst[i] = '0; e_map[i] = '0; e_marn[i] = '0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 0;
        set_idle();
        @(posedge clk);
        #1;
        model_reset();
        rst = 1;
    endtask

    task automatic test_reset();
        rst = 0;
        set_idle();
        inst_ready = 1;
        dec_valid = 1; dec_dst_valid = 3'b001; freed_prns_valid = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        total++; if (inst_valid !== 1'b0) $display("FAIL reset_inst_valid got=%0d want=0", inst_valid); else passed++;
        total++; if (dec_ready !== 1'b0) $display("FAIL reset_dec_ready got=%0d want=0", dec_ready); else passed++;
        total++; if (pc !== 64'd0) $display("FAIL reset_pc got=%0h want=0", pc); else passed++;
        total++; if (dst_prn_valid !== 3'b000 || mapping_inputs_valid !== 3'b000)
            $display("FAIL reset_valids got=%b/%b want=000/000", dst_prn_valid, mapping_inputs_valid); else passed++;
        total++; if (dst_prn[0] !== 6'd0 || src_prn[0] !== 6'd0)
            $display("FAIL reset_data got=%0d/%0d want=0/0", dst_prn[0], src_prn[0]); else passed++;
        set_idle();
        model_reset();
        rst = 1;
    endtask

    task automatic test_basic();
        do_reset();
        inst_ready = 1; dec_valid = 1; dec_pc = 64'h1000;
        dec_dst_valid = 3'b001; dec_dst_arn[0] = 1;
        dec_src_valid = 3'b001; dec_src_arn[0] = 1;
        step();
        total++; if (rdy_seen !== 1'b1) $display("FAIL basic_ready got=%0d want=1", rdy_seen); else passed++;
        total++; if (inst_valid !== 1'b1) $display("FAIL basic_valid got=%0d want=1", inst_valid); else passed++;
        total++; if (src_prn[0] !== 6'd1) $display("FAIL basic_src got=%0d want=1", src_prn[0]); else passed++;
        total++; if (dst_prn[0] !== 6'd32) $display("FAIL basic_dst got=%0d want=32", dst_prn[0]); else passed++;
        total++; if (mapping_inputs_prn[0] !== 6'd1) $display("FAIL basic_map got=%0d want=1", mapping_inputs_prn[0]); else passed++;
        total++; if (mapping_inputs_arn[0] !== 33'd1) $display("FAIL basic_marn got=%0d want=1", mapping_inputs_arn[0]); else passed++;
        total++; if (pc !== 64'h1000 || dst_prn_valid !== 3'b001)
            $display("FAIL basic_pc got=%0h/%b want=1000/001", pc, dst_prn_valid); else passed++;
    endtask

    task automatic test_stall();
        inst_ready = 0; dec_valid = 1; dec_pc = 64'h2000;
        dec_dst_valid = 3'b001; dec_dst_arn[0] = 2; dec_src_valid = 3'b000;
        for (int c = 0; c < 2; c++) begin
            step();
            total++; if (rdy_seen !== 1'b0) $display("FAIL stall_ready c=%0d got=%0d want=0", c, rdy_seen); else passed++;
            total++; if (inst_valid !== 1'b1 || pc !== 64'h1000 || dst_prn[0] !== 6'd32)
                $display("FAIL stall_hold c=%0d got=%0d/%0h/%0d want=1/1000/32", c, inst_valid, pc, dst_prn[0]); else passed++;
        end
        inst_ready = 1;
        step();
        total++; if (rdy_seen !== 1'b1) $display("FAIL release_ready got=%0d want=1", rdy_seen); else passed++;
        total++; if (pc !== 64'h2000 || dst_prn[0] !== 6'd33)
            $display("FAIL release_next got=%0h/%0d want=2000/33", pc, dst_prn[0]); else passed++;
    endtask

    task automatic test_exhaust();
        do_reset();
        inst_ready = 1; dec_valid = 1; dec_dst_valid = 3'b001; dec_dst_arn[0] = 3;
        for (int i = 0; i < 32; i++) begin
            dec_pc = 64'(i);
            step();
            total++; if (dst_prn[0] !== 6'(32 + i)) $display("FAIL exhaust_alloc i=%0d got=%0d want=%0d", i, dst_prn[0], 32 + i); else passed++;
        end
        step();
        total++; if (rdy_seen !== 1'b0) $display("FAIL exhaust_ready got=%0d want=0", rdy_seen); else passed++;
        total++; if (inst_valid !== 1'b0) $display("FAIL exhaust_clear got=%0d want=0", inst_valid); else passed++;
        freed_prns_valid = 3'b001; freed_prns[0] = 7;
        step();
        freed_prns_valid = 3'b000;
`ifdef RENAME_FREE_BYPASS_EN
        total++; if (rdy_seen !== 1'b1) $display("FAIL bypass_ready got=%0d want=1", rdy_seen); else passed++;
        total++; if (dst_prn[0] !== 6'd7 || inst_valid !== 1'b1)
            $display("FAIL bypass_dst got=%0d/%0d want=7/1", dst_prn[0], inst_valid); else passed++;
`else
        total++; if (rdy_seen !== 1'b0) $display("FAIL nobypass_ready got=%0d want=0", rdy_seen); else passed++;
        step();
        total++; if (rdy_seen !== 1'b1) $display("FAIL nobypass_next got=%0d want=1", rdy_seen); else passed++;
        total++; if (dst_prn[0] !== 6'd7 || inst_valid !== 1'b1)
            $display("FAIL nobypass_dst got=%0d/%0d want=7/1", dst_prn[0], inst_valid); else passed++;
`endif
    endtask

    task automatic test_same_dst();
        do_reset();
        inst_ready = 1; dec_valid = 1;
        dec_dst_valid = 3'b011; dec_dst_arn[0] = 5; dec_dst_arn[1] = 5;
        step();
        total++; if (dst_prn[0] !== 6'd32 || dst_prn[1] !== 6'd33)
            $display("FAIL samedst_dst got=%0d,%0d want=32,33", dst_prn[0], dst_prn[1]); else passed++;
        total++; if (mapping_inputs_prn[0] !== 6'd5 || mapping_inputs_prn[1] !== 6'd32)
            $display("FAIL samedst_map got=%0d,%0d want=5,32", mapping_inputs_prn[0], mapping_inputs_prn[1]); else passed++;
        total++; if (dst_prn_valid !== 3'b011 || dst_prn[2] !== 6'd0)
            $display("FAIL samedst_slot2 got=%b/%0d want=011/0", dst_prn_valid, dst_prn[2]); else passed++;
        dec_dst_valid = 3'b000; dec_src_valid = 3'b001; dec_src_arn[0] = 5;
        step();
        total++; if (src_prn[0] !== 6'd33) $display("FAIL samedst_src got=%0d want=33", src_prn[0]); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        inst_ready = 0; dec_valid = 1; dec_pc = 64'h77;
        dec_dst_valid = 3'b001; dec_dst_arn[0] = 9;
        step();
        freed_prns_valid = 3'b111; freed_prns[0] = 1; freed_prns[1] = 2; freed_prns[2] = 3;
        rst = 0;
        #1;
        total++; if (inst_valid !== 1'b0 || pc !== 64'd0)
            $display("FAIL midreset_clear got=%0d/%0h want=0/0", inst_valid, pc); else passed++;
        @(posedge clk);
        #1;
        model_reset();
        set_idle();
        rst = 1;
        inst_ready = 1; dec_valid = 1; dec_dst_valid = 3'b001; dec_dst_arn[0] = 9;
        step();
        total++; if (dst_prn[0] !== 6'd32 || inst_valid !== 1'b1)
            $display("FAIL midreset_first got=%0d/%0d want=32/1", dst_prn[0], inst_valid); else passed++;
    endtask

    task automatic test_overflow();
        do_reset();
        inst_ready = 1;
        for (int c = 0; c < 11; c++) begin
            for (int k = 0; k < N; k++) begin
                freed_prns_valid[k] = (3 * c + k) < 32;
                freed_prns[k] = 6'(3 * c + k);
            end
            step();
        end
        freed_prns_valid = 3'b111; freed_prns[0] = 40; freed_prns[1] = 41; freed_prns[2] = 42;
        step();
        freed_prns_valid = 3'b000;
        dec_valid = 1; dec_dst_valid = 3'b001;
        for (int i = 0; i < 64; i++) begin
            dec_dst_arn[0] = 5'(i);
            step();
            total++; if (dst_prn[0] !== 6'(i < 32 ? 32 + i : i - 32))
                $display("FAIL overflow_alloc i=%0d got=%0d want=%0d", i, dst_prn[0], i < 32 ? 32 + i : i - 32); else passed++;
        end
        step();
        total++; if (rdy_seen !== 1'b0) $display("FAIL overflow_empty got=%0d want=0", rdy_seen); else passed++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            dec_valid = ($urandom % 4) != 0;
            inst_ready = ($urandom % 4) != 0;
            dec_pc = {$urandom, $urandom};
            dec_src_valid = 3'($urandom);
            dec_dst_valid = 3'($urandom);
            for (int i = 0; i < N; i++) begin
                dec_src_arn[i] = 5'($urandom);
                dec_dst_arn[i] = 5'($urandom % 8);
                freed_prns_valid[i] = ($urandom % 4) == 0;
                freed_prns[i] = 6'($urandom);
            end
            step();
            total++; if (rdy_seen !== exp_rdy) $display("FAIL rand_ready c=%0d got=%0d want=%0d", c, rdy_seen, exp_rdy); else passed++;
            total++; if (inst_valid !== e_valid || pc !== e_pc)
                $display("FAIL rand_head c=%0d got=%0d/%0h want=%0d/%0h", c, inst_valid, pc, e_valid, e_pc); else passed++;
            total++; if (src_prn_valid !== e_sv || dst_prn_valid !== e_dv || mapping_inputs_valid !== e_mv)
                $display("FAIL rand_valids c=%0d got=%b/%b/%b want=%b/%b/%b", c, src_prn_valid, dst_prn_valid,
                         mapping_inputs_valid, e_sv, e_dv, e_mv); else passed++;
            for (int i = 0; i < N; i++) begin
                total++; if (src_prn[i] !== e_src[i] || dst_prn[i] !== e_dst[i] ||
                             mapping_inputs_prn[i] !== e_map[i] || mapping_inputs_arn[i] !== e_marn[i])
                    $display("FAIL rand_slot c=%0d i=%0d got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d", c, i,
                             src_prn[i], dst_prn[i], mapping_inputs_prn[i], mapping_inputs_arn[i],
                             e_src[i], e_dst[i], e_map[i], e_marn[i]); else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_exhaust();
        test_same_dst();
        test_reset_mid();
        test_overflow();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
